// File: rtl/mic_mem_if_pkg.sv
// Shared types for the Mic memory interface: access-FSM states, access kind,
// and the derivation of the fetch-lane index width.
package mic_mem_if_pkg;

  typedef enum logic [1:0] {IDLE, DATA, FETCH} mem_state_t;

  typedef enum logic {ACC_READ, ACC_WRITE} acc_kind_t;

  // Number of lane-select bits in a fetch address (0 when a word is one unit).
  function automatic int lane_bits(input int word, input int mbr_w);
    return (word / mbr_w > 1) ? $clog2(word / mbr_w) : 0;
  endfunction

endpackage

// File: rtl/mic_mem_if_lane_sel.sv
// Combinational lane mux: picks one MBR_W-wide unit out of a memory word,
// lane 0 being the least-significant unit.
module mic_lane_sel #(
  parameter int WORD  = 32,
  parameter int MBR_W = 8,
  parameter int LSW   = 2
) (
  input  logic [WORD-1:0]  word,
  input  logic [LSW-1:0]   lane,
  output logic [MBR_W-1:0] unit
);

  localparam int NL = WORD / MBR_W;

  always_comb begin
    unit = '0;
    for (int i = 0; i < NL; i++) begin
      if (int'(lane) == i) unit = word[i*MBR_W +: MBR_W];
    end
  end

endmodule

// File: rtl/mic_mem_if.sv
// Memory interface between the Mic datapath and a single-port word memory:
// serialises data (MAR/MDR) and byte-fetch (PC/MBR) accesses with a fixed wait.
//
// state | meaning
// IDLE  | port free, requests sampled
// DATA  | data read or write in progress, fetch may be queued behind it
// FETCH | fetch-unit read in progress
module mic_mem_if
  import mic_mem_if_pkg::*;
#(
  parameter int WORD        = 32,
  parameter int NBITS       = 12,
  parameter int MBR_W       = 8,
  parameter int WAIT_CYCLES = 1,
  localparam int LB         = lane_bits(WORD, MBR_W)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_req,
  input  logic                  wr_req,
  input  logic                  fetch_req,
  input  logic [NBITS-1:0]      mar_in,
  input  logic [WORD-1:0]       mdr_in,
  input  logic [NBITS+LB-1:0]   pc_in,
  input  logic [WORD-1:0]       mem_in,
  output logic [NBITS-1:0]      mem_addr,
  output logic [WORD-1:0]       mem_out,
  output logic                  write_enb,
  output logic [WORD-1:0]       mdr_out,
  output logic                  mdr_valid,
  output logic [MBR_W-1:0]      mbr_out,
  output logic                  mbr_valid,
  output logic                  stall
);

  localparam int LSW = (LB > 0) ? LB : 1;
  localparam int CW  = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(WAIT_CYCLES);

  mem_state_t           state;
  acc_kind_t            kind;
  logic [CW-1:0]        cnt;
  logic                 fetch_pend;
  logic [NBITS+LB-1:0]  pc_q;
  logic [LSW-1:0]       lane_idx;
  logic [MBR_W-1:0]     lane_unit;

  if (LB > 0) begin : g_lane
    assign lane_idx = pc_q[LSW-1:0];
  end else begin : g_nolane
    assign lane_idx = '0;
  end

  mic_lane_sel #(
    .WORD  (WORD),
    .MBR_W (MBR_W),
    .LSW   (LSW)
  ) u_lane_sel (
    .word (mem_in),
    .lane (lane_idx),
    .unit (lane_unit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      kind       <= ACC_READ;
      cnt        <= '0;
      fetch_pend <= 1'b0;
      pc_q       <= '0;
      mem_addr   <= '0;
      mem_out    <= '0;
      write_enb  <= 1'b0;
      mdr_out    <= '0;
      mdr_valid  <= 1'b0;
      mbr_out    <= '0;
      mbr_valid  <= 1'b0;
      stall      <= 1'b0;
    end else begin
      mdr_valid <= 1'b0;
      mbr_valid <= 1'b0;
      case (state)
        IDLE: begin
          write_enb <= 1'b0;
          stall     <= 1'b0;
          if (wr_req || rd_req) begin
            state      <= DATA;
            stall      <= 1'b1;
            cnt        <= '0;
            kind       <= wr_req ? ACC_WRITE : ACC_READ;
            mem_addr   <= mar_in;
            fetch_pend <= fetch_req;
            if (wr_req) begin
              mem_out   <= mdr_in;
              write_enb <= 1'b1;
            end
            if (fetch_req) pc_q <= pc_in;
          end else if (fetch_req) begin
            state    <= FETCH;
            stall    <= 1'b1;
            cnt      <= '0;
            pc_q     <= pc_in;
            mem_addr <= pc_in[NBITS+LB-1:LB];
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt       <= CNT_DONE;
            write_enb <= 1'b0;
            if (kind == ACC_READ) begin
              mdr_out   <= mem_in;
              mdr_valid <= 1'b1;
            end
            // A queued fetch follows immediately without a pass through IDLE.
            if (fetch_pend) begin
              state      <= FETCH;
              cnt        <= '0;
              fetch_pend <= 1'b0;
              mem_addr   <= pc_q[NBITS+LB-1:LB];
            end else begin
              state <= IDLE;
              stall <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FETCH: begin
          if (cnt == CNT_LAST) begin
            cnt       <= CNT_DONE;
            mbr_out   <= lane_unit;
            mbr_valid <= 1'b1;
            state     <= IDLE;
            stall     <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          stall <= 1'b0;
        end
      endcase
    end
  end

endmodule
